// File: rtl/noc_router3.sv
`default_nettype none
// ============================================================================
// Module   : noc_router3
// Brief    : 3-port (East/West/Local) 1-D NoC router with per-input FIFOs,
//            destination routing and round-robin arbitrated registered outputs.
// Revision : 1.0 - initial release
// ============================================================================
module noc_router3 #(
  parameter int         DATA_WIDTH = 16,
  parameter int         FIFO_DEPTH = 32,
  parameter logic [1:0] LOCAL_ID   = 2'b00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeE,
  input  logic                  writeW,
  input  logic                  writeL,
  input  logic                  readFullE,
  input  logic                  readFullW,
  input  logic                  readFullL,
  input  logic                  read_almostfullE,
  input  logic                  read_almostfullW,
  input  logic                  read_almostfullL,
  input  logic [DATA_WIDTH-1:0] dataInE,
  input  logic [DATA_WIDTH-1:0] dataInW,
  input  logic [DATA_WIDTH-1:0] dataInL,
  output logic [DATA_WIDTH-1:0] dataOutE,
  output logic [DATA_WIDTH-1:0] dataOutW,
  output logic [DATA_WIDTH-1:0] dataOutL,
  output logic                  writeOutE,
  output logic                  writeOutW,
  output logic                  writeOutL,
  output logic                  fullE,
  output logic                  fullW,
  output logic                  fullL,
  output logic                  almost_fullE,
  output logic                  almost_fullW,
  output logic                  almost_fullL
);

  localparam int         c_AW     = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_DEPTH  = (c_AW+1)'(FIFO_DEPTH);
  localparam logic [c_AW:0] c_AFULL  = (c_AW+1)'(FIFO_DEPTH - 1);
  localparam logic [1:0] c_E      = 2'd0;
  localparam logic [1:0] c_W      = 2'd1;
  localparam logic [1:0] c_L      = 2'd2;

  logic [2:0]            w_write;
  logic [2:0]            w_full_dn;
  logic [2:0]            w_afull_dn;
  logic [DATA_WIDTH-1:0] w_din   [3];
  logic [DATA_WIDTH-1:0] w_head  [3];
  logic [1:0]            w_route [3];
  logic [2:0]            w_req   [3];
  logic [1:0]            w_sel   [3];
  logic [DATA_WIDTH-1:0] w_dout  [3];
  logic [2:0]            w_empty;
  logic [2:0]            w_full;
  logic [2:0]            w_afull;
  logic [2:0]            w_valid_head;
  logic [2:0]            w_discard;
  logic [2:0]            w_pop;
  logic [2:0]            w_fire;
  logic [2:0]            w_wout;

  assign w_write    = {writeL, writeW, writeE};
  assign w_full_dn  = {readFullL, readFullW, readFullE};
  assign w_afull_dn = {read_almostfullL, read_almostfullW, read_almostfullE};
  assign w_din[0]   = dataInE;
  assign w_din[1]   = dataInW;
  assign w_din[2]   = dataInL;

  // Input FIFOs: index 0=East, 1=West, 2=Local
  for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW:0]         r_count;
    logic                  w_push;
    logic [1:0]            w_dest;

    assign w_full[gi]       = (r_count == c_DEPTH);
    assign w_afull[gi]      = (r_count >= c_AFULL);
    assign w_empty[gi]      = (r_count == '0);
    assign w_push           = w_write[gi] & ~w_full[gi];
    assign w_head[gi]       = r_mem[r_rd_ptr];
    assign w_dest           = w_head[gi][2:1];
    assign w_valid_head[gi] = ~w_empty[gi] & w_head[gi][0];
    // Invalid heads are dropped without competing for an output
    assign w_discard[gi]    = ~w_empty[gi] & ~w_head[gi][0];
    assign w_route[gi]      = (w_dest == LOCAL_ID) ? c_L :
                              ((w_dest > LOCAL_ID) ? c_E : c_W);
    assign w_pop[gi]        = w_discard[gi]
                            | (w_fire[0] & (w_sel[0] == 2'(gi)))
                            | (w_fire[1] & (w_sel[1] == 2'(gi)))
                            | (w_fire[2] & (w_sel[2] == 2'(gi)));

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_din[gi];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[gi])  r_rd_ptr <= r_rd_ptr + 1'b1;
        case ({w_push, w_pop[gi]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Output ports: arbitration and registered flit/strobe per output
  for (genvar go = 0; go < 3; go++) begin : g_out
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_wout;
    logic [1:0]            r_rr;
    logic [1:0]            w_c0;
    logic [1:0]            w_c1;
    logic                  w_gnt;
    logic [1:0]            w_pick;
    logic                  w_ready;

    for (genvar gi = 0; gi < 3; gi++) begin : g_req
      assign w_req[go][gi] = w_valid_head[gi] & (w_route[gi] == 2'(go));
    end

    // Search order starts just after the last winner
    assign w_c0 = (r_rr == c_L) ? c_E : r_rr + 2'd1;
    assign w_c1 = (w_c0 == c_L) ? c_E : w_c0 + 2'd1;

    always_comb begin
      w_gnt  = 1'b0;
      w_pick = r_rr;
      if (w_req[go][w_c0]) begin
        w_gnt  = 1'b1;
        w_pick = w_c0;
      end else if (w_req[go][w_c1]) begin
        w_gnt  = 1'b1;
        w_pick = w_c1;
      end else if (w_req[go][r_rr]) begin
        w_gnt  = 1'b1;
        w_pick = r_rr;
      end
    end

    assign w_ready    = ~((r_wout & w_afull_dn[go]) | (~r_wout & w_full_dn[go]));
    assign w_fire[go] = w_gnt & w_ready;
    assign w_sel[go]  = w_pick;
    assign w_dout[go] = r_dout;
    assign w_wout[go] = r_wout;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_dout <= '0;
        r_wout <= 1'b0;
        r_rr   <= c_L;
      end else if (w_fire[go]) begin
        r_dout <= w_head[w_pick];
        r_wout <= 1'b1;
        r_rr   <= w_pick;
      end else begin
        r_wout <= 1'b0;
      end
    end
  end

  assign dataOutE     = w_dout[0];
  assign dataOutW     = w_dout[1];
  assign dataOutL     = w_dout[2];
  assign writeOutE    = w_wout[0];
  assign writeOutW    = w_wout[1];
  assign writeOutL    = w_wout[2];
  assign fullE        = w_full[0];
  assign fullW        = w_full[1];
  assign fullL        = w_full[2];
  assign almost_fullE = w_afull[0];
  assign almost_fullW = w_afull[1];
  assign almost_fullL = w_afull[2];

endmodule
`default_nettype wire

// File: tb/tb_noc_router3.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_router3
// Brief    : Scoreboard bench for noc_router3 (LOCAL_ID=2'b10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_router3;
  localparam int         DW  = 16;
  localparam logic [1:0] LID = 2'b10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    wr = '0;
  logic [2:0]    rfull = '0;
  logic [2:0]    rafull = '0;
  logic [DW-1:0] din [3];
  logic [DW-1:0] dout [3];
  logic [2:0]    wout, full, afull;
  logic [DW-1:0] dataOutE, dataOutW, dataOutL;
  logic writeOutE, writeOutW, writeOutL;
  logic fullE, fullW, fullL, almost_fullE, almost_fullW, almost_fullL;

  assign dout[0] = dataOutE;
  assign dout[1] = dataOutW;
  assign dout[2] = dataOutL;
  assign wout    = {writeOutL, writeOutW, writeOutE};
  assign full    = {fullL, fullW, fullE};
  assign afull   = {almost_fullL, almost_fullW, almost_fullE};

  noc_router3 #(.DATA_WIDTH(DW), .FIFO_DEPTH(32), .LOCAL_ID(LID)) dut (
    .clk(clk), .reset(reset),
    .writeE(wr[0]), .writeW(wr[1]), .writeL(wr[2]),
    .readFullE(rfull[0]), .readFullW(rfull[1]), .readFullL(rfull[2]),
    .read_almostfullE(rafull[0]), .read_almostfullW(rafull[1]), .read_almostfullL(rafull[2]),
    .dataInE(din[0]), .dataInW(din[1]), .dataInL(din[2]),
    .dataOutE(dataOutE), .dataOutW(dataOutW), .dataOutL(dataOutL),
    .writeOutE(writeOutE), .writeOutW(writeOutW), .writeOutL(writeOutL),
    .fullE(fullE), .fullW(fullW), .fullL(fullL),
    .almost_fullE(almost_fullE), .almost_fullW(almost_fullW), .almost_fullL(almost_fullL)
  );

  // Expected flit, keyed by output port and source port
  typedef struct packed {
    logic [1:0]    o;
    logic [1:0]    s;
    logic [DW-1:0] d;
  } exp_t;

  exp_t       sb[$];
  int         west_src[$];
  logic       rec_west = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] seq = '0;

  function automatic logic [1:0] route_of(input logic [1:0] dest);
    if (dest == LID)     return 2'd2;
    else if (dest > LID) return 2'd0;
    else                 return 2'd1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload carries source port and sequence number so the monitor can key it
  task automatic mk(input logic v, input logic [1:0] dest, input logic [1:0] s,
                    output logic [DW-1:0] f);
    f = {s, seq, 2'($urandom), dest, v};
    seq = seq + 9'd1;
  endtask

  task automatic expect_flit(input logic [DW-1:0] f, input logic [1:0] s);
    exp_t e;
    if (f[0]) begin
      e.o = route_of(f[2:1]);
      e.s = s;
      e.d = f;
      sb.push_back(e);
    end
  endtask

  task automatic mon(input int o);
    logic [DW-1:0] d;
    logic [1:0]    s;
    int            k;
    d = dout[o];
    s = d[DW-1 -: 2];
    k = -1;
    for (int j = 0; j < sb.size(); j++)
      if (k < 0 && sb[j].o == 2'(o) && sb[j].s == s) k = j;
    checks++;
    if (k < 0) begin
      errors++;
      $display("FAIL out%0d unexpected flit: got %h expected none", o, d);
    end else begin
      if (sb[k].d !== d) begin
        errors++;
        $display("FAIL out%0d data: got %h expected %h", o, d, sb[k].d);
      end
      sb.delete(k);
    end
    if (rec_west && o == 1) west_src.push_back(int'(s));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    wr = '0; rfull = '0; rafull = '0;
    while (sb.size() != 0 && n < 600) begin
      step();
      n++;
    end
    step(); step(); step();
    check({name, " drained"}, sb.size(), 0);
  endtask

  task automatic rand_cycle();
    logic [DW-1:0] f;
    for (int i = 0; i < 3; i++) begin
      wr[i] = 1'b0;
      if (!full[i] && $urandom_range(1, 0) == 1) begin
        mk($urandom_range(7, 0) != 0, 2'($urandom), 2'(i), f);
        din[i] = f;
        wr[i]  = 1'b1;
        expect_flit(f, 2'(i));
      end
    end
    for (int o = 0; o < 3; o++) begin
      rfull[o]  = ($urandom_range(3, 0) == 0);
      rafull[o] = ($urandom_range(2, 0) == 0);
    end
    step();
  endtask

  task automatic check_idle(input string name);
    for (int o = 0; o < 3; o++) begin
      check($sformatf("%s wout%0d", name, o), wout[o], 0);
      check($sformatf("%s dout%0d", name, o), dout[o], 0);
      check($sformatf("%s full%0d", name, o), full[o], 0);
      check($sformatf("%s afull%0d", name, o), afull[o], 0);
    end
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [DW-1:0] fe, fw, fl;
    for (int i = 0; i < 3; i++) din[i] = '0;

    fork
      forever begin
        @(negedge clk);
        if (reset)
          for (int o = 0; o < 3; o++)
            if (wout[o]) mon(o);
      end
    join_none

    // Reset state, asserted before any clock edge
    #1 reset = 1'b0;
    #2 check_idle("reset");
    step(); step();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("idle wout c%0d", c), wout, 0);
    end

    // One flit per input, each to a different output
    mk(1'b1, 2'b11, 2'd0, fe); din[0] = fe; expect_flit(fe, 2'd0);
    mk(1'b1, 2'b01, 2'd1, fw); din[1] = fw; expect_flit(fw, 2'd1);
    mk(1'b1, 2'b10, 2'd2, fl); din[2] = fl; expect_flit(fl, 2'd2);
    wr = 3'b111;
    step();
    wr = '0;
    check("route wout early", wout, 0);
    step();
    check("route wout", wout, 3'b111);
    check("route east data", dout[0], fe);
    check("route west data", dout[1], fw);
    check("route local data", dout[2], fl);

    // Invalid flit is discarded; following flit sees normal latency
    mk(1'b0, 2'b10, 2'd2, f); din[2] = f;
    wr = 3'b100;
    step();
    wr = '0;
    step();
    check("invalid wout", wout, 0);
    check("invalid afull L", afull[2], 0);
    mk(1'b1, 2'b10, 2'd2, fl); din[2] = fl; expect_flit(fl, 2'd2);
    wr = 3'b100;
    step();
    wr = '0;
    check("post-invalid wout early", wout, 0);
    step();
    check("post-invalid wout", wout, 3'b100);
    check("post-invalid data", dout[2], fl);
    drain("invalid");

    // Blocked West output: East FIFO fills, extra writes dropped
    rfull[1] = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      mk(1'b1, 2'b00, 2'd0, f); din[0] = f;
      wr = 3'b001;
      if (k <= 32) expect_flit(f, 2'd0);
      step();
      if (k == 30) begin
        check("fill30 afull", afull[0], 0);
        check("fill30 full", full[0], 0);
      end
      if (k == 31) begin
        check("fill31 afull", afull[0], 1);
        check("fill31 full", full[0], 0);
      end
      if (k == 32 || k == 34) begin
        check($sformatf("fill%0d full", k), full[0], 1);
        check($sformatf("fill%0d afull", k), afull[0], 1);
        check($sformatf("fill%0d wout", k), wout, 0);
      end
    end
    wr = '0;
    drain("blocked");
    check("drained full E", full[0], 0);

    // Reset pulsed in the middle of random traffic
    repeat (30) rand_cycle();
    wr = '0;
    #2 reset = 1'b0;
    #1 check_idle("midreset");
    sb.delete();
    step(); step();
    reset = 1'b1;
    rfull = '0; rafull = '0;

    // All inputs to West every cycle: round robin from East after reset
    rec_west = 1'b1;
    west_src.delete();
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 3; i++) begin
        mk(1'b1, 2'b00, 2'(i), f); din[i] = f; expect_flit(f, 2'(i));
      end
      wr = 3'b111;
      step();
    end
    wr = '0;
    drain("contend");
    rec_west = 1'b0;
    check("contend count", west_src.size(), 36);
    for (int k = 0; k < west_src.size(); k++)
      check($sformatf("contend rr k%0d", k), west_src[k], k % 3);

    // Long random run
    repeat (1500) rand_cycle();
    wr = '0;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
